// File: rtl/seg7_decoder_if.sv
// seg7_decoder_if: display bus plus the decoded results of a seven-segment receiver.
//   nSEG   [7:0]  segment bus, active-low, [7]=dp, [6:0]=g..a (driven by master)
//   nAN    [3:0]  anode bus, active-low, bit i selects digit slot i (driven by master)
//   DIGITS [15:0] decoded values, slot i at [4i+3:4i]          (driven by slave)
//   VALID  [3:0]  slot holds a committed valid digit             (driven by slave)
//   ERR    [3:0]  last commit to slot was an illegal pattern     (driven by slave)
//   DP     [3:0]  decimal point of the last commit to slot       (driven by slave)
//   UPD           one-cycle pulse per commit                     (driven by slave)
interface seg7_decoder_if;
  logic [7:0]  nSEG;
  logic [3:0]  nAN;
  logic [15:0] DIGITS;
  logic [3:0]  VALID;
  logic [3:0]  ERR;
  logic [3:0]  DP;
  logic        UPD;

  modport master (
    output nSEG, nAN,
    input  DIGITS, VALID, ERR, DP, UPD
  );

  modport slave (
    input  nSEG, nAN,
    output DIGITS, VALID, ERR, DP, UPD
  );
endinterface

// File: rtl/seg7_decoder.sv
// seg7_decoder: watches an active-low segment/anode bus, waits for a single-digit pattern to
// stay stable for STABLE_CYC further cycles, then decodes it into the selected digit slot.
//   STABLE_CYC  extra stable cycles required before a commit (1..65535)
//   CLK         system clock, rising edge
//   RST         asynchronous active-high reset
//   bus         seg7_decoder_if.slave: nSEG/nAN in; DIGITS/VALID/ERR/DP/UPD out (all registered)
module seg7_decoder #(
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic            CLK,
  input  logic            RST,
  seg7_decoder_if.slave   bus
);

  localparam logic [15:0] StableCyc   = 16'(STABLE_CYC);
  localparam logic [15:0] StableCycM1 = 16'(STABLE_CYC - 1);

  logic [11:0] samp_q, samp_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  valid_q, valid_d;
  logic [3:0]  err_q, err_d;
  logic [3:0]  dp_q, dp_d;
  logic        upd_q, upd_d;

  logic [11:0] in_w;
  logic        same;
  logic        single_an;
  logic [1:0]  slot;
  logic        dec_legal;
  logic [3:0]  dec_val;
  logic        blank;
  logic        commit;

  assign in_w  = {bus.nAN, bus.nSEG};
  assign same  = (in_w == samp_q);
  assign blank = (bus.nSEG[6:0] == 7'h7F);

  // Exactly one anode low selects a slot; anything else never commits.
  always_comb begin
    single_an = 1'b1;
    slot      = 2'd0;
    case (bus.nAN)
      4'b1110: slot = 2'd0;
      4'b1101: slot = 2'd1;
      4'b1011: slot = 2'd2;
      4'b0111: slot = 2'd3;
      default: single_an = 1'b0;
    endcase
  end

  always_comb begin
    dec_legal = 1'b1;
    dec_val   = 4'd0;
    case (bus.nSEG[6:0])
      7'h40:        dec_val = 4'd0;
      7'h79:        dec_val = 4'd1;
      7'h24:        dec_val = 4'd2;
      7'h30:        dec_val = 4'd3;
      7'h19:        dec_val = 4'd4;
      7'h12:        dec_val = 4'd5;
      7'h02:        dec_val = 4'd6;
      7'h58, 7'h78: dec_val = 4'd7;
      7'h00:        dec_val = 4'd8;
      7'h10, 7'h18: dec_val = 4'd9;
      default:      dec_legal = 1'b0;
    endcase
  end

  // cnt saturates at StableCyc, so the StableCycM1 match fires once per stable pattern.
  assign commit = same && (cnt_q == StableCycM1) && single_an;

  always_comb begin
    samp_d = samp_q;
    cnt_d  = cnt_q;
    if (!same) begin
      samp_d = in_w;
      cnt_d  = 16'd0;
    end else if (cnt_q < StableCyc) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    err_d    = err_q;
    dp_d     = dp_q;
    upd_d    = commit;
    if (commit) begin
      dp_d[slot] = ~bus.nSEG[7];
      if (blank) begin
        valid_d[slot] = 1'b0;
        err_d[slot]   = 1'b0;
      end else if (dec_legal) begin
        digits_d[{slot, 2'b00} +: 4] = dec_val;
        valid_d[slot]                = 1'b1;
        err_d[slot]                  = 1'b0;
      end else begin
        valid_d[slot] = 1'b0;
        err_d[slot]   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      samp_q   <= 12'hFFF;
      cnt_q    <= 16'd0;
      digits_q <= 16'd0;
      valid_q  <= 4'd0;
      err_q    <= 4'd0;
      dp_q     <= 4'd0;
      upd_q    <= 1'b0;
    end else begin
      samp_q   <= samp_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      dp_q     <= dp_d;
      upd_q    <= upd_d;
    end
  end

  assign bus.DIGITS = digits_q;
  assign bus.VALID  = valid_q;
  assign bus.ERR    = err_q;
  assign bus.DP     = dp_q;
  assign bus.UPD    = upd_q;

endmodule

// File: tb/tb_seg7_decoder.sv
// tb_seg7_decoder: directed stimulus with a scoreboard of expected commit results.
module tb_seg7_decoder;

  localparam int unsigned Stable = 4;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  valid;
    logic [3:0]  err;
    logic [3:0]  dp;
  } exp_t;

  logic CLK;
  logic RST;
  seg7_decoder_if bus ();

  seg7_decoder #(.STABLE_CYC(Stable)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int passed = 0;
  int total  = 0;
  int upd_cnt = 0;
  int pushes  = 0;
  exp_t sb[$];

  // Reference model state
  logic [15:0] m_digits;
  logic [3:0]  m_valid, m_err, m_dp;
  logic [11:0] m_prev;
  int          m_run;

  logic [6:0] lut_code [12] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                7'h02, 7'h58, 7'h78, 7'h00, 7'h10, 7'h18};
  logic [3:0] lut_val  [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
                                4'd6, 4'd7, 4'd7, 4'd8, 4'd9, 4'd9};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_digits = 16'd0;
    m_valid  = 4'd0;
    m_err    = 4'd0;
    m_dp     = 4'd0;
    m_prev   = 12'hFFF;
    m_run    = 0;
  endtask

  task automatic model_commit(input logic [3:0] an, input logic [7:0] sg);
    int   slot;
    logic legal;
    logic [3:0] val;
    exp_t e;
    slot  = 0;
    for (int i = 0; i < 4; i++) if (!an[i]) slot = i;
    legal = 1'b0;
    val   = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (lut_code[i] == sg[6:0]) begin
        legal = 1'b1;
        val   = lut_val[i];
      end
    end
    m_dp[slot] = ~sg[7];
    if (sg[6:0] == 7'h7F) begin
      m_valid[slot] = 1'b0;
      m_err[slot]   = 1'b0;
    end else if (legal) begin
      m_digits[slot*4 +: 4] = val;
      m_valid[slot]         = 1'b1;
      m_err[slot]           = 1'b0;
    end else begin
      m_valid[slot] = 1'b0;
      m_err[slot]   = 1'b1;
    end
    e.digits = m_digits;
    e.valid  = m_valid;
    e.err    = m_err;
    e.dp     = m_dp;
    sb.push_back(e);
    pushes++;
  endtask

  // Drive a pattern for n rising edges; push an expectation if this hold completes stability.
  task automatic hold(input logic [3:0] an, input logic [7:0] sg, input int n);
    logic [11:0] pat;
    int old;
    pat = {an, sg};
    bus.nAN  = an;
    bus.nSEG = sg;
    if (pat == m_prev) begin
      old   = m_run;
      m_run = m_run + n;
    end else begin
      old    = 0;
      m_run  = n;
      m_prev = pat;
    end
    if (old < Stable + 1 && m_run >= Stable + 1 && $countones(~an) == 1) model_commit(an, sg);
    repeat (n) @(negedge CLK);
  endtask

  task automatic settle_check_upd(input string tag);
    #1;
    check(tag, upd_cnt, pushes);
  endtask

  // Monitor: every UPD pulse must match the next scoreboard entry.
  always @(negedge CLK) begin
    if (!RST && bus.UPD === 1'b1) begin
      upd_cnt++;
      check("upd_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("digits", 32'(bus.DIGITS), 32'(e.digits));
        check("valid", 32'(bus.VALID), 32'(e.valid));
        check("err", 32'(bus.ERR), 32'(e.err));
        check("dp", 32'(bus.DP), 32'(e.dp));
      end
    end
  end

  initial begin
    model_reset();
    RST      = 1'b1;
    bus.nAN  = 4'hF;
    bus.nSEG = 8'hFF;
    repeat (2) @(negedge CLK);
    #1;
    check("rst_digits", 32'(bus.DIGITS), 32'h0);
    check("rst_valid", 32'(bus.VALID), 32'h0);
    check("rst_err", 32'(bus.ERR), 32'h0);
    check("rst_dp", 32'(bus.DP), 32'h0);
    check("rst_upd", 32'(bus.UPD), 32'h0);
    @(negedge CLK);
    RST = 1'b0;

    // Single commit of digit 2 on slot 0, then no repeat while held
    hold(4'b1110, 8'hA4, 5);
    settle_check_upd("first_commit");
    check("slot0_is_2", 32'(bus.DIGITS[3:0]), 32'd2);
    hold(4'b1110, 8'hA4, 10);
    settle_check_upd("no_recommit");

    // Interrupted pattern does not commit; the following one does
    hold(4'b1111, 8'hFF, 2);
    hold(4'b1110, 8'hA4, 3);
    hold(4'b1110, 8'h99, 5);
    settle_check_upd("interrupted");
    check("slot0_is_4", 32'(bus.DIGITS[3:0]), 32'd4);

    // Multiplexed scan
    hold(4'b0111, 8'h90, 8);
    hold(4'b1011, 8'h92, 8);
    hold(4'b1101, 8'h40, 8);
    hold(4'b1110, 8'h7F, 8);
    settle_check_upd("scan");
    check("scan_digits", 32'(bus.DIGITS), 32'h9504);
    check("scan_valid", 32'(bus.VALID), 32'hE);

    // Slot 1: digit 8 with dp, blank without dp, illegal without dp
    hold(4'b1101, 8'h00, 6);
    #1 check("dp1_lit", 32'(bus.DP[1]), 32'd1);
    hold(4'b1101, 8'hFF, 6);
    #1 check("blank_valid1", 32'(bus.VALID[1]), 32'd0);
    hold(4'b1101, 8'hFE, 6);
    #1 check("illegal_err1", 32'(bus.ERR[1]), 32'd1);
    check("slot1_kept_8", 32'(bus.DIGITS[7:4]), 32'd8);
    check("dp1_off", 32'(bus.DP[1]), 32'd0);
    settle_check_upd("slot1_seq");

    // Every legal code on slot 2, then multi-anode and no-anode patterns
    for (int i = 0; i < 12; i++) hold(4'b1011, {1'b1, lut_code[i]}, 6);
    settle_check_upd("all_codes");
    hold(4'b1100, 8'hF9, 8);
    hold(4'b1111, 8'hA4, 8);
    settle_check_upd("no_commit_anodes");

    // Async reset during count 3 of 4
    hold(4'b1110, 8'hF9, 4);
    #2 RST = 1'b1;
    #1;
    check("arst_digits", 32'(bus.DIGITS), 32'h0);
    check("arst_valid", 32'(bus.VALID), 32'h0);
    check("arst_err", 32'(bus.ERR), 32'h0);
    check("arst_dp", 32'(bus.DP), 32'h0);
    check("arst_upd", 32'(bus.UPD), 32'h0);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    hold(4'b1110, 8'hF9, 4);
    settle_check_upd("post_rst_short");
    hold(4'b1110, 8'hF9, 1);
    settle_check_upd("post_rst_commit");
    check("post_rst_slot0", 32'(bus.DIGITS[3:0]), 32'd1);

    repeat (3) @(negedge CLK);
    #1 check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
